conc_stim_sequencer: RTL and testbench

Synthesizable stimulus sequencer that replays a host-loaded vector memory into a DUT's input ports, one 32-bit vector per handshake. Each vector carries a 31-bit `datai` value (bits 30:0) and the `__obs` observation flag (bit 31). It sits between the host/loader and the DUT, for example the `b14` core. It replaces free-running testbench program-counter logic with a handshaked, stoppable, loopable controller.

---
 rtl/conc_stim_pkg.sv | 9 +
 rtl/conc_stim_ram.sv | 31 +++
 rtl/conc_stim_sequencer.sv | 111 +++++++++++
 tb/tb_conc_stim_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/conc_stim_pkg.sv
// Shared types and default sizes for the stimulus sequencer.
`timescale 1ns/1ps
package conc_stim_pkg;
  localparam int DATA_W_DEF = 31;
  localparam int DEPTH_DEF  = 64;
  localparam int VEC_W      = DATA_W_DEF + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} stim_state_e;
endpackage

// File: rtl/conc_stim_ram.sv
// Vector store: one write port, one synchronous read port with one-cycle latency.
`timescale 1ns/1ps
module conc_stim_ram #(
  parameter int VEC_W  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [VEC_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [VEC_W-1:0]  o_rdata
);
  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [VEC_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the read register is cleared so the presented vector reads as zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/conc_stim_sequencer.sv
// Handshaked replay controller: streams host-loaded vectors to a DUT, optionally looping.
`timescale 1ns/1ps
module conc_stim_sequencer
  import conc_stim_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W:0]   load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W:0]   length,
  output logic              stim_valid,
  input  logic              stim_ready,
  output logic [DATA_W-1:0] stim_data,
  output logic              stim_obs,
  output logic              busy,
  output logic              done,
  output logic [15:0]       vec_count
);
  localparam int VW = DATA_W + 1;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   len_t;
  localparam len_t DEPTH_L = len_t'(DEPTH);

  stim_state_e r_state;
  ptr_t        r_ptr;
  len_t        r_len;
  logic        r_loop;
  logic        r_done;
  logic [15:0] r_cnt;

  logic        w_go, w_fire, w_last, w_we, w_re;
  ptr_t        w_raddr;
  logic [VW-1:0] w_rdata;

  assign load_ready = (r_state == IDLE) & ~start;
  assign w_we       = load_valid & load_ready;
  assign w_go       = (r_state == IDLE) & start & ~stop & (length != '0);
  assign w_fire     = (r_state == RUN) & stim_ready;
  assign w_last     = ({1'b0, r_ptr} == (r_len - len_t'(1)));

  // Reading ahead in the fire cycle keeps one vector per cycle, including across the wrap.
  assign w_re    = w_go | w_fire;
  assign w_raddr = (w_go | w_last) ? '0 : r_ptr + ptr_t'(1);

  conc_stim_ram #(
    .VEC_W  (VW),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fire && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= PRIME;
            r_len   <= (length > DEPTH_L) ? DEPTH_L : length;
            r_loop  <= loop;
            r_ptr   <= '0;
            r_cnt   <= '0;
          end
        end
        PRIME: r_state <= stop ? IDLE : RUN;
        RUN: begin
          if (w_fire) r_ptr <= w_last ? '0 : r_ptr + ptr_t'(1);
          if (stop) begin
            r_state <= IDLE;
          end else if (w_fire && w_last && !r_loop) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim_valid = (r_state == RUN);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign vec_count  = r_cnt;
  assign stim_data  = w_rdata[DATA_W-1:0];
  assign stim_obs   = w_rdata[DATA_W];
endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Directed-plus-random bench for conc_stim_sequencer against an array-based replay model.
`timescale 1ns/1ps
module tb_conc_stim_sequencer;
  localparam int DATA_W = 31;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_valid, load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W:0]   load_data;
  logic              start, stop, loop;
  logic [ADDR_W:0]   length;
  logic              stim_valid, stim_ready;
  logic [DATA_W-1:0] stim_data;
  logic              stim_obs, busy, done;
  logic [15:0]       vec_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [DEPTH];

  always #5 clock = ~clock;

  conc_stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .loop(loop), .length(length),
    .stim_valid(stim_valid), .stim_ready(stim_ready), .stim_data(stim_data), .stim_obs(stim_obs),
    .busy(busy), .done(done), .vec_count(vec_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = ADDR_W'(a);
    load_data  = d;
    chk("load_ready_idle", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    model[a] = d;
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
  // stop_at: nonzero stops the run in the same cycle as that fire.
  task automatic run_prog(input int len, input bit lp, input int rmode, input int stop_at, input bit poke);
    int L, k, cyc;
    bit rdy, fin, stopped;
    L = (len > DEPTH) ? DEPTH : len;
    length = (ADDR_W+1)'(len);
    loop   = lp;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("prime_valid", {31'd0, stim_valid}, 32'd0);
    chk("prime_busy", {31'd0, busy}, 32'd1);
    if (poke) begin
      load_valid = 1'b1;
      load_addr  = '0;
      load_data  = 32'h7FFF_0000;
    end
    step();
    k = 0; cyc = 0; fin = 1'b0; stopped = 1'b0;
    while (!fin && cyc < 2000) begin
      chk("run_valid", {31'd0, stim_valid}, 32'd1);
      chk("run_data", {1'b0, stim_data}, {1'b0, model[k % L][30:0]});
      chk("run_obs", {31'd0, stim_obs}, {31'd0, model[k % L][31]});
      chk("run_count", {16'd0, vec_count}, 32'(k));
      chk("run_done_low", {31'd0, done}, 32'd0);
      if (poke) chk("load_ready_busy", {31'd0, load_ready}, 32'd0);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      stim_ready = rdy;
      if (rdy) k++;
      if (stop_at != 0 && rdy && k == stop_at) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
      step();
      stim_ready = 1'b0;
      stop = 1'b0;
      cyc++;
      if (stopped || (!lp && k == L)) fin = 1'b1;
    end
    load_valid = 1'b0;
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL run_timeout: observed=%0d fires expected=%0d", k, L);
    end
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_valid", {31'd0, stim_valid}, 32'd0);
    chk("end_done", {31'd0, done}, stopped ? 32'd0 : 32'd1);
    chk("end_count", {16'd0, vec_count}, 32'(k));
    step();
    chk("done_pulse_once", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; length = '0; stim_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, stim_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {1'b0, stim_data}, 32'd0);
    chk("rst_obs", {31'd0, stim_obs}, 32'd0);
    chk("rst_count", {16'd0, vec_count}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    step();

    load(0, 32'h8000_0001);
    load(1, 32'h0000_0002);
    load(2, 32'h8000_0003);
    load(3, 32'h0000_0004);

    run_prog(4, 1'b0, 0, 0, 1'b0);
    run_prog(4, 1'b0, 1, 0, 1'b0);
    run_prog(3, 1'b1, 0, 10, 1'b0);

    length = '0;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("len0_ignored", {31'd0, busy}, 32'd0);
    step();
    chk("len0_still_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    run_prog(100, 1'b0, 2, 0, 1'b0);

    run_prog(4, 1'b0, 0, 0, 1'b1);
    run_prog(4, 1'b0, 2, 0, 1'b0);

    length = 7'd4;
    start  = 1'b1;
    stop   = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", {31'd0, busy}, 32'd0);

    length = 7'd4;
    loop   = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    stim_ready = 1'b1;
    step();
    step();
    step();
    chk("pre_reset_count", {16'd0, vec_count}, 32'd2);
    chk("pre_reset_data", {1'b0, stim_data}, {1'b0, model[2][30:0]});
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, stim_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_data", {1'b0, stim_data}, 32'd0);
    chk("async_rst_obs", {31'd0, stim_obs}, 32'd0);
    chk("async_rst_count", {16'd0, vec_count}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_load_ready", {31'd0, load_ready}, 32'd1);
    stim_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_prog(4, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
